cram_async_ctrl: RTL and testbench

- Parametrised asynchronous CRAM/PSRAM controller for the NeoGeo cart memory path.
- Converts single OPB-style requests from the APF/core side into timed async SRAM-mode cycles on a 16-bit CRAM with two chip enables.
- Adds programmable read/write strobe widths, recovery time and automatic 32-bit splitting into two 16-bit accesses.
- Tristate resolution stays in the top-level wrapper; this block exposes separate dq in/out/enable.

---
 rtl/cram_async_ctrl_if.sv | 25 ++
 rtl/cram_async_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cram_async_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_async_ctrl_if.sv
// OPB-style request/response bundle between the APF/core side and the CRAM controller.
// The master drives a request; the slave (controller) answers with a one-cycle ack.
interface cram_async_ctrl_if #(
    parameter int ADDR_W = 22
);
    logic              OPB_select;
    logic              OPB_RNW;
    logic              OPB_32Bit;
    logic [ADDR_W+1:0] OPB_ABus;
    logic [3:0]        OPB_BE;
    logic [31:0]       OPB_DBus;
    logic [31:0]       Sln_DBus;
    logic              Sln_xferAck;
    logic              busy;

    modport master (
        output OPB_select, OPB_RNW, OPB_32Bit, OPB_ABus, OPB_BE, OPB_DBus,
        input  Sln_DBus, Sln_xferAck, busy
    );

    modport slave (
        input  OPB_select, OPB_RNW, OPB_32Bit, OPB_ABus, OPB_BE, OPB_DBus,
        output Sln_DBus, Sln_xferAck, busy
    );
endinterface

// File: rtl/cram_async_ctrl.sv
// Async SRAM-mode CRAM/PSRAM controller: turns one OPB request into one or two timed
// 16-bit accesses with programmable strobe widths and CE recovery between them.
module cram_async_ctrl #(
    parameter int ADDR_W   = 22,
    parameter int WAIT_RD  = 4,
    parameter int WAIT_WR  = 4,
    parameter int RECOVERY = 1
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst_n,
    cram_async_ctrl_if.slave  opb,
    output logic [ADDR_W-1:0] cram_a,
    output logic [15:0]       cram_dq_o,
    input  logic [15:0]       cram_dq_i,
    output logic              cram_dq_oe,
    output logic              cram_ce0_n,
    output logic              cram_ce1_n,
    output logic              cram_oe_n,
    output logic              cram_we_n,
    output logic              cram_ub_n,
    output logic              cram_lb_n,
    output logic              cram_adv_n
);

    localparam int MAX_A = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
    localparam int MAX_W = (MAX_A > RECOVERY) ? MAX_A : RECOVERY;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(WAIT_RD - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WAIT_WR - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'((RECOVERY > 0) ? RECOVERY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RD, S_WR, S_HOLD, S_RECOV, S_ACK
    } state_t;

    state_t            state_q, state_d, done_tgt;
    logic [CNT_W-1:0]  cnt_q;
    logic              armed_q;
    logic              rnw_q, b32_q, chip_q, half_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q;

    logic accept, first_half, next_half, capture, half_done, more;
    logic chip_d, half_d, rnw_d, ce_d;
    logic [3:0] be_d;
    logic [1:0] lane_d;
    logic abus_byte_unused;

    assign abus_byte_unused = opb.OPB_ABus[0];

    // A second half is needed for 32-bit reads, or 32-bit writes with any upper byte enabled.
    assign more     = !half_q && b32_q && (rnw_q || (be_q[3:2] != 2'b00));
    assign done_tgt = more ? S_SETUP : S_ACK;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        first_half = 1'b0;
        next_half  = 1'b0;
        capture    = 1'b0;
        half_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (opb.OPB_select && armed_q) begin
                    accept = 1'b1;
                    if (opb.OPB_RNW || (opb.OPB_BE[1:0] != 2'b00)) begin
                        state_d = S_SETUP;
                    end else if (opb.OPB_32Bit && (opb.OPB_BE[3:2] != 2'b00)) begin
                        state_d    = S_SETUP;
                        first_half = 1'b1;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_SETUP: state_d = rnw_q ? S_RD : S_WR;
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    capture   = 1'b1;
                    half_done = 1'b1;
                end
            end
            S_WR:    if (cnt_q == WR_LAST) state_d = S_HOLD;
            S_HOLD:  half_done = 1'b1;
            S_RECOV: begin
                if (cnt_q == RECOV_LAST) begin
                    state_d   = done_tgt;
                    next_half = more;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // With no recovery the next half starts straight from the end of this one.
        if (half_done) begin
            if (RECOVERY > 0) begin
                state_d = S_RECOV;
            end else begin
                state_d   = done_tgt;
                next_half = more;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            if (accept)
                armed_q <= 1'b0;
            else if (!opb.OPB_select)
                armed_q <= 1'b1;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rnw_q   <= 1'b0;
            b32_q   <= 1'b0;
            chip_q  <= 1'b0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                rnw_q   <= opb.OPB_RNW;
                b32_q   <= opb.OPB_32Bit;
                chip_q  <= opb.OPB_ABus[ADDR_W+1];
                half_q  <= first_half;
                addr_q  <= opb.OPB_ABus[ADDR_W:1] + ADDR_W'(first_half);
                be_q    <= opb.OPB_BE;
                wdata_q <= opb.OPB_DBus;
                rdata_q <= '0;
            end else if (next_half) begin
                half_q <= 1'b1;
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (capture) begin
                if (half_q) rdata_q[31:16] <= cram_dq_i;
                else        rdata_q[15:0]  <= cram_dq_i;
            end
        end
    end

    // Pin controls are registered from the next state so strobes never glitch.
    assign chip_d = accept ? opb.OPB_ABus[ADDR_W+1] : chip_q;
    assign half_d = accept ? first_half : (next_half | half_q);
    assign rnw_d  = accept ? opb.OPB_RNW : rnw_q;
    assign be_d   = accept ? opb.OPB_BE : be_q;
    assign lane_d = half_d ? be_d[3:2] : be_d[1:0];
    assign ce_d   = (state_d == S_SETUP) || (state_d == S_RD) ||
                    (state_d == S_WR)    || (state_d == S_HOLD);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cram_ce0_n <= 1'b1;
            cram_ce1_n <= 1'b1;
            cram_oe_n  <= 1'b1;
            cram_we_n  <= 1'b1;
            cram_ub_n  <= 1'b1;
            cram_lb_n  <= 1'b1;
            cram_dq_oe <= 1'b0;
        end else begin
            cram_ce0_n <= !(ce_d && !chip_d);
            cram_ce1_n <= !(ce_d && chip_d);
            cram_oe_n  <= (state_d != S_RD);
            cram_we_n  <= (state_d != S_WR);
            cram_ub_n  <= (state_d == S_RD) ? 1'b0 : ((state_d == S_WR) ? !lane_d[1] : 1'b1);
            cram_lb_n  <= (state_d == S_RD) ? 1'b0 : ((state_d == S_WR) ? !lane_d[0] : 1'b1);
            cram_dq_oe <= !rnw_d && ((state_d == S_SETUP) || (state_d == S_WR) ||
                                     (state_d == S_HOLD));
        end
    end

    assign cram_a          = addr_q;
    assign cram_dq_o       = half_q ? wdata_q[31:16] : wdata_q[15:0];
    assign cram_adv_n      = 1'b0;
    assign opb.Sln_xferAck = (state_q == S_ACK);
    assign opb.Sln_DBus    = (state_q == S_ACK) ? rdata_q : 32'h0;
    assign opb.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cram_async_ctrl.sv
// Directed bench for cram_async_ctrl: default build plus a WAIT_RD=2/RECOVERY=0 build,
// with a small CRAM read model and per-request strobe/latency monitoring.
module tb_cram_async_ctrl;
    localparam int ADDR_W = 22;
    localparam int WIN    = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel2 = 1'b0;
    logic        select = 1'b0, rnw = 1'b0, b32 = 1'b0;
    logic [23:0] abus = '0;
    logic [3:0]  be = '0;
    logic [31:0] db = '0;

    cram_async_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();
    cram_async_ctrl_if #(.ADDR_W(ADDR_W)) bus2 ();

    assign bus1.OPB_select = select & ~sel2;
    assign bus1.OPB_RNW    = rnw;
    assign bus1.OPB_32Bit  = b32;
    assign bus1.OPB_ABus   = abus;
    assign bus1.OPB_BE     = be;
    assign bus1.OPB_DBus   = db;
    assign bus2.OPB_select = select & sel2;
    assign bus2.OPB_RNW    = rnw;
    assign bus2.OPB_32Bit  = b32;
    assign bus2.OPB_ABus   = abus;
    assign bus2.OPB_BE     = be;
    assign bus2.OPB_DBus   = db;

    logic [21:0] a1, a2;
    logic [15:0] dqo1, dqo2, dqi1, dqi2;
    logic dqoe1, ce0n1, ce1n1, oen1, wen1, ubn1, lbn1, advn1;
    logic dqoe2, ce0n2, ce1n2, oen2, wen2, ubn2, lbn2, advn2;

    function automatic logic [15:0] model_rd(input logic chip, input logic [21:0] a);
        if (chip && a == 22'h3FFFFF) return 16'h1234;
        if (chip && a == 22'h000000) return 16'h5678;
        return a[15:0] ^ 16'hA5A5;
    endfunction

    assign dqi1 = oen1 ? 16'hDEAD : model_rd(~ce1n1, a1);
    assign dqi2 = oen2 ? 16'hDEAD : model_rd(~ce1n2, a2);

    cram_async_ctrl dut1 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus1),
        .cram_a(a1), .cram_dq_o(dqo1), .cram_dq_i(dqi1), .cram_dq_oe(dqoe1),
        .cram_ce0_n(ce0n1), .cram_ce1_n(ce1n1), .cram_oe_n(oen1), .cram_we_n(wen1),
        .cram_ub_n(ubn1), .cram_lb_n(lbn1), .cram_adv_n(advn1)
    );

    cram_async_ctrl #(.WAIT_RD(2), .RECOVERY(0)) dut2 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus2),
        .cram_a(a2), .cram_dq_o(dqo2), .cram_dq_i(dqi2), .cram_dq_oe(dqoe2),
        .cram_ce0_n(ce0n2), .cram_ce1_n(ce1n2), .cram_oe_n(oen2), .cram_we_n(wen2),
        .cram_ub_n(ubn2), .cram_lb_n(lbn2), .cram_adv_n(advn2)
    );

    logic [21:0] m_a;
    logic [15:0] m_dqo;
    logic [31:0] m_dbus;
    logic m_ack, m_busy, m_dqoe, m_ce0, m_ce1, m_oe, m_we, m_ub, m_lb;
    assign m_a    = sel2 ? a2 : a1;
    assign m_dqo  = sel2 ? dqo2 : dqo1;
    assign m_dbus = sel2 ? bus2.Sln_DBus : bus1.Sln_DBus;
    assign m_ack  = sel2 ? bus2.Sln_xferAck : bus1.Sln_xferAck;
    assign m_busy = sel2 ? bus2.busy : bus1.busy;
    assign m_dqoe = sel2 ? dqoe2 : dqoe1;
    assign m_ce0  = sel2 ? ce0n2 : ce0n1;
    assign m_ce1  = sel2 ? ce1n2 : ce1n1;
    assign m_oe   = sel2 ? oen2 : oen1;
    assign m_we   = sel2 ? wen2 : wen1;
    assign m_ub   = sel2 ? ubn2 : ubn1;
    assign m_lb   = sel2 ? lbn2 : lbn1;

    int total = 0;
    int bad = 0;

    int ack_cyc, n_ack, we_cnt, oe_cnt, gap, nwr, nrd;
    logic ce0_seen, ce1_seen, we_prev, oe_prev;
    logic [31:0] ack_data;
    logic [21:0] wr_addr [2];
    logic [21:0] rd_addr [2];
    logic [15:0] wr_data [2];
    logic        wr_ub [2];
    logic        wr_lb [2];
    logic        wr_oe [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, and monitor WIN cycles.
    task automatic do_req(input logic r, input logic w32, input logic [23:0] ab,
                          input logic [3:0] b, input logic [31:0] d, input int hold_after);
        rnw = r; b32 = w32; abus = ab; be = b; db = d; select = 1'b1;
        ack_cyc = -1; n_ack = 0; we_cnt = 0; oe_cnt = 0; gap = 0; nwr = 0; nrd = 0;
        ce0_seen = 1'b0; ce1_seen = 1'b0; we_prev = 1'b1; oe_prev = 1'b1; ack_data = '0;
        for (int i = 0; i < 2; i++) begin
            wr_addr[i] = '0; rd_addr[i] = '0; wr_data[i] = '0;
            wr_ub[i] = 1'b1; wr_lb[i] = 1'b1; wr_oe[i] = 1'b0;
        end
        @(posedge clk);
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rnw = ~rnw; b32 = ~b32; abus = ~abus; be = ~be; db = ~db;
            end
            if (!m_ce0) ce0_seen = 1'b1;
            if (!m_ce1) ce1_seen = 1'b1;
            if (m_busy && !m_ack && m_ce0 && m_ce1) gap++;
            if (!m_we) begin
                we_cnt++;
                if (we_prev && nwr < 2) begin
                    wr_addr[nwr] = m_a; wr_data[nwr] = m_dqo;
                    wr_ub[nwr] = m_ub; wr_lb[nwr] = m_lb; wr_oe[nwr] = m_dqoe;
                    nwr++;
                end
            end
            if (!m_oe) begin
                oe_cnt++;
                if (oe_prev && nrd < 2) begin
                    rd_addr[nrd] = m_a;
                    nrd++;
                end
            end
            we_prev = m_we;
            oe_prev = m_oe;
            if (m_ack) begin
                n_ack++;
                if (ack_cyc < 0) begin
                    ack_cyc = c;
                    ack_data = m_dbus;
                end
            end
            if (ack_cyc >= 0 && c >= ack_cyc + hold_after) select = 1'b0;
        end
        select = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_ce0_n", 32'(ce0n1), 1);
        check("rst_ce1_n", 32'(ce1n1), 1);
        check("rst_oe_we", {30'd0, oen1, wen1}, 3);
        check("rst_ub_lb", {30'd0, ubn1, lbn1}, 3);
        check("rst_dq_oe", 32'(dqoe1), 0);
        check("rst_a", 32'(a1), 0);
        check("rst_dq_o", 32'(dqo1), 0);
        check("rst_dbus", bus1.Sln_DBus, 0);
        check("rst_ack_busy", {30'd0, bus1.Sln_xferAck, bus1.busy}, 0);
        check("adv_n", 32'(advn1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // write16, word 8 on CE0, only the upper byte lane
        do_req(1'b0, 1'b0, 24'h000010, 4'b0010, 32'h0000ABCD, 0);
        check("w16_ack_cyc", ack_cyc, 8);
        check("w16_n_ack", n_ack, 1);
        check("w16_we_cnt", we_cnt, 4);
        check("w16_nwr", nwr, 1);
        check("w16_addr", 32'(wr_addr[0]), 32'h8);
        check("w16_data", 32'(wr_data[0]), 32'hABCD);
        check("w16_lanes", {30'd0, wr_ub[0], wr_lb[0]}, 32'b01);
        check("w16_dq_oe", 32'(wr_oe[0]), 1);
        check("w16_ce_seen", {30'd0, ce0_seen, ce1_seen}, 32'b10);
        check("w16_dbus", ack_data, 0);

        // read32 wrapping at the top word of CE1
        do_req(1'b1, 1'b1, 24'hFFFFFE, 4'b1111, 32'h0, 0);
        check("r32_ack_cyc", ack_cyc, 13);
        check("r32_data", ack_data, 32'h56781234);
        check("r32_addr0", 32'(rd_addr[0]), 32'h3FFFFF);
        check("r32_addr1", 32'(rd_addr[1]), 32'h0);
        check("r32_ce_seen", {30'd0, ce0_seen, ce1_seen}, 32'b01);
        check("r32_oe_cnt", oe_cnt, 8);
        check("r32_gap", gap, 2);

        // write32 with only the upper half enabled
        do_req(1'b0, 1'b1, 24'h000040, 4'b1100, 32'h11112222, 0);
        check("w32hi_nwr", nwr, 1);
        check("w32hi_addr", 32'(wr_addr[0]), 32'h21);
        check("w32hi_data", 32'(wr_data[0]), 32'h1111);
        check("w32hi_lanes", {30'd0, wr_ub[0], wr_lb[0]}, 0);
        check("w32hi_ack_cyc", ack_cyc, 8);

        // write with no byte enables
        do_req(1'b0, 1'b1, 24'h000040, 4'b0000, 32'h33334444, 0);
        check("wbe0_we_cnt", we_cnt, 0);
        check("wbe0_ack_cyc", ack_cyc, 1);
        check("wbe0_ce_seen", {30'd0, ce0_seen, ce1_seen}, 0);

        // read16 word 0x55 on CE0
        do_req(1'b1, 1'b0, 24'h0000AA, 4'b0011, 32'h0, 0);
        check("r16_ack_cyc", ack_cyc, 7);
        check("r16_data", ack_data, 32'h0000A5F0);
        check("r16_oe_cnt", oe_cnt, 4);

        // full write32
        do_req(1'b0, 1'b1, 24'h000020, 4'b1111, 32'hCAFEF00D, 0);
        check("w32_ack_cyc", ack_cyc, 15);
        check("w32_nwr", nwr, 2);
        check("w32_addr0", 32'(wr_addr[0]), 32'h10);
        check("w32_addr1", 32'(wr_addr[1]), 32'h11);
        check("w32_data0", 32'(wr_data[0]), 32'hF00D);
        check("w32_data1", 32'(wr_data[1]), 32'hCAFE);

        // select held 3 clocks past ack
        do_req(1'b0, 1'b0, 24'h000010, 4'b0011, 32'h00005A5A, 3);
        check("hold3_n_ack", n_ack, 1);
        check("hold3_we_cnt", we_cnt, 4);

        // select held through the whole window, then low one clock, then a new request
        do_req(1'b1, 1'b0, 24'h0000AA, 4'b0011, 32'h0, 1000);
        check("holdall_n_ack", n_ack, 1);
        check("holdall_oe_cnt", oe_cnt, 4);
        do_req(1'b1, 1'b0, 24'h0000AA, 4'b0011, 32'h0, 0);
        check("rearm_ack_cyc", ack_cyc, 7);
        check("rearm_data", ack_data, 32'h0000A5F0);

        // reset in the middle of a write strobe
        rnw = 1'b0; b32 = 1'b0; abus = 24'h000010; be = 4'b0011; db = 32'h00001111;
        select = 1'b1;
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (m_we !== 1'b0 && k < 10);
        check("mid_we_reached", 32'(m_we), 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_we_n", 32'(wen1), 1);
        check("mid_ce_n", {30'd0, ce0n1, ce1n1}, 3);
        check("mid_dq_oe", 32'(dqoe1), 0);
        check("mid_busy_ack", {30'd0, bus1.busy, bus1.Sln_xferAck}, 0);
        select = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.Sln_xferAck) k++;
        end
        check("mid_no_ack", k, 0);
        do_req(1'b0, 1'b0, 24'h000010, 4'b0001, 32'h00002468, 0);
        check("post_rst_ack_cyc", ack_cyc, 8);
        check("post_rst_data", 32'(wr_data[0]), 32'h2468);

        // fast build: WAIT_RD=2, RECOVERY=0
        sel2 = 1'b1;
        @(negedge clk);
        do_req(1'b1, 1'b0, 24'h0000AA, 4'b0011, 32'h0, 0);
        check("fast_r16_ack_cyc", ack_cyc, 4);
        check("fast_r16_data", ack_data, 32'h0000A5F0);
        do_req(1'b1, 1'b1, 24'hFFFFFE, 4'b1111, 32'h0, 0);
        check("fast_r32_ack_cyc", ack_cyc, 7);
        check("fast_r32_gap", gap, 0);
        check("fast_r32_data", ack_data, 32'h56781234);
        check("fast_r32_addr1", 32'(rd_addr[1]), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
